dest_data_seq: RTL and testbench

DEST_DATA_SEQ -- requirements
Module: dest_data_seq

---
 rtl/dest_data_seq.sv | 81 ++++++++
 tb/tb_dest_data_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dest_data_seq.sv
// dest_data_seq: steers a merged AXI-Stream to one of N_DESTS outputs, one {pid,len,dest} entry at a time.
module dest_data_seq #(
  parameter int DATA_BITS = 64,
  parameter int N_DESTS = 1,
  parameter int PID_BITS = 4,
  parameter int BLEN_BITS = 8,
  // one spare code beyond N_DESTS-1 so out-of-range (drained) entries can be expressed
  localparam int N_DESTS_BITS = $clog2(N_DESTS + 1),
  localparam int MUX_BITS = PID_BITS + BLEN_BITS + N_DESTS_BITS
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   s_mux_valid,
  output logic                   s_mux_ready,
  input  logic [MUX_BITS-1:0]    s_mux_data,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [DATA_BITS-1:0]   s_axis_tdata,
  input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  output logic [N_DESTS-1:0]     m_axis_tvalid,
  input  logic [N_DESTS-1:0]     m_axis_tready,
  output logic [DATA_BITS-1:0]   m_axis_tdata,
  output logic [DATA_BITS/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic [PID_BITS-1:0]    m_axis_tid
);
  typedef enum logic {ST_IDLE, ST_MUX} state_t;
  typedef struct packed {
    logic [PID_BITS-1:0]     pid;
    logic [BLEN_BITS-1:0]    len;
    logic [N_DESTS_BITS-1:0] dest;
  } mux_user_t;
  localparam logic [N_DESTS_BITS-1:0] N_DESTS_L = N_DESTS_BITS'(N_DESTS);
  state_t state_q, state_d;
  logic [N_DESTS_BITS-1:0] dest_q, dest_d;
  logic [PID_BITS-1:0] pid_q, pid_d;
  logic [BLEN_BITS-1:0] cnt_q, cnt_d;
  logic [N_DESTS-1:0] sel;
  mux_user_t ent;
  logic mux, in_rng, last, beat, load, unused_tlast;
  assign ent = mux_user_t'(s_mux_data);
  // beat boundaries come from the entry length, so the input tlast carries no information
  assign unused_tlast = s_axis_tlast;
  for (genvar i = 0; i < N_DESTS; i++) begin : g_sel
    assign sel[i] = dest_q == N_DESTS_BITS'(i);
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_IDLE;
      dest_q  <= '0;
      pid_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      pid_q   <= pid_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    load    = s_mux_valid && s_mux_ready;
    state_d = load ? ST_MUX : (beat && last) ? ST_IDLE : state_q;
    dest_d  = load ? ent.dest : dest_q;
    pid_d   = load ? ent.pid : pid_q;
    cnt_d   = load ? ent.len : (beat && !last) ? cnt_q - BLEN_BITS'(1) : cnt_q;
  end
  always_comb begin
    mux           = state_q == ST_MUX;
    in_rng        = dest_q < N_DESTS_L;
    last          = cnt_q == '0;
    s_axis_tready = mux && (!in_rng || |(m_axis_tready & sel));
    beat          = s_axis_tvalid && s_axis_tready;
    s_mux_ready   = !mux || (beat && last);
    m_axis_tvalid = (mux && s_axis_tvalid) ? sel : '0;
    m_axis_tlast  = mux && last;
    m_axis_tid    = mux ? pid_q : '0;
    m_axis_tdata  = s_axis_tdata;
    m_axis_tkeep  = s_axis_tkeep;
  end
endmodule

// File: tb/tb_dest_data_seq.sv
// tb_dest_data_seq: directed cycle vectors plus a randomized scoreboard run for dest_data_seq.
module tb_dest_data_seq;
  localparam int DW = 32, ND = 4, PB = 4, BB = 3, DB = 3;
  logic aclk = 0;
  logic areset;
  logic s_mux_valid, s_mux_ready;
  logic [PB+BB+DB-1:0] s_mux_data;
  logic s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [DW-1:0] s_axis_tdata;
  logic [DW/8-1:0] s_axis_tkeep;
  logic [ND-1:0] m_axis_tvalid, m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [DW/8-1:0] m_axis_tkeep;
  logic m_axis_tlast;
  logic [PB-1:0] m_axis_tid;
  always #5 aclk = ~aclk;
  dest_data_seq #(.DATA_BITS(DW), .N_DESTS(ND), .PID_BITS(PB), .BLEN_BITS(BB)) dut (
    .aclk(aclk), .areset(areset),
    .s_mux_valid(s_mux_valid), .s_mux_ready(s_mux_ready), .s_mux_data(s_mux_data),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid)
  );
  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  typedef struct {
    logic rst, mv;
    logic [3:0] pid;
    logic [2:0] len, dest;
    logic tv;
    logic [3:0] mr;
    logic e_mr, e_str;
    logic [3:0] e_mtv;
    logic e_tl;
    logic [3:0] e_tid;
  } vec_t;
  typedef struct {
    logic [2:0] dest;
    logic [31:0] d;
    logic l;
    logic [3:0] pid;
  } beat_t;
  vec_t v[$];
  beat_t exp_q[$];
  logic [9:0] ents[$];
  function automatic vec_t mk(logic rst, logic mv, logic [3:0] pid, logic [2:0] len, logic [2:0] dest,
                              logic tv, logic [3:0] mr, logic e_mr, logic e_str, logic [3:0] e_mtv,
                              logic e_tl, logic [3:0] e_tid);
    return '{rst, mv, pid, len, dest, tv, mr, e_mr, e_str, e_mtv, e_tl, e_tid};
  endfunction
  initial begin
    int total, ei, wi, cyc, dd;
    beat_t b;
    // single entry pid3 len3 dest1
    v.push_back(mk(0,0,0,0,0,0,4'hF, 1,0,4'h0,0,0));
    v.push_back(mk(0,1,3,3,1,0,4'hF, 1,0,4'h0,0,0));
    repeat (3) v.push_back(mk(0,0,0,0,0,1,4'hF, 0,1,4'b0010,0,3));
    v.push_back(mk(0,0,0,0,0,1,4'hF, 1,1,4'b0010,1,3));
    v.push_back(mk(0,0,0,0,0,1,4'hF, 1,0,4'h0,0,0));
    // back-to-back entries, next entry already valid
    v.push_back(mk(0,1,5,1,0,1,4'hF, 1,0,4'h0,0,0));
    v.push_back(mk(0,1,6,0,2,1,4'hF, 0,1,4'b0001,0,5));
    v.push_back(mk(0,1,6,0,2,1,4'hF, 1,1,4'b0001,1,5));
    v.push_back(mk(0,0,0,0,0,1,4'hF, 1,1,4'b0100,1,6));
    v.push_back(mk(0,0,0,0,0,0,4'hF, 1,0,4'h0,0,0));
    // max length with alternating backpressure on dest 2
    v.push_back(mk(0,1,9,7,2,0,4'hF, 1,0,4'h0,0,0));
    for (int k = 0; k < 8; k++) begin
      v.push_back(mk(0,0,0,0,0,1,4'b0100, k==7,1,4'b0100,k==7,9));
      if (k < 7) v.push_back(mk(0,0,0,0,0,1,4'b1011, 0,0,4'b0100,k==6,9));
    end
    v.push_back(mk(0,0,0,0,0,1,4'hF, 1,0,4'h0,0,0));
    // out-of-range dest drains without any output valid
    v.push_back(mk(0,1,2,2,5,0,4'hF, 1,0,4'h0,0,0));
    v.push_back(mk(0,0,0,0,0,1,4'h0, 0,1,4'h0,0,2));
    v.push_back(mk(0,0,0,0,0,0,4'h0, 0,1,4'h0,0,2));
    v.push_back(mk(0,0,0,0,0,1,4'h0, 0,1,4'h0,0,2));
    v.push_back(mk(0,0,0,0,0,1,4'h0, 1,1,4'h0,1,2));
    v.push_back(mk(0,0,0,0,0,1,4'hF, 1,0,4'h0,0,0));
    // reset mid-transfer, then reset while an entry is offered
    v.push_back(mk(0,1,4,5,0,0,4'hF, 1,0,4'h0,0,0));
    v.push_back(mk(0,0,0,0,0,1,4'hF, 0,1,4'b0001,0,4));
    v.push_back(mk(0,0,0,0,0,1,4'hF, 0,1,4'b0001,0,4));
    v.push_back(mk(1,1,7,0,3,1,4'hF, 0,1,4'b0001,0,4));
    v.push_back(mk(1,1,7,0,3,1,4'hF, 1,0,4'h0,0,0));
    v.push_back(mk(0,0,0,0,0,1,4'hF, 1,0,4'h0,0,0));
    v.push_back(mk(0,1,1,0,3,0,4'hF, 1,0,4'h0,0,0));
    v.push_back(mk(0,0,0,0,0,1,4'b1000, 1,1,4'b1000,1,1));
    v.push_back(mk(0,0,0,0,0,0,4'hF, 1,0,4'h0,0,0));
    areset = 1; s_mux_valid = 0; s_mux_data = '0; s_axis_tvalid = 0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 0; m_axis_tready = '0;
    repeat (2) @(posedge aclk);
    for (int i = 0; i < v.size(); i++) begin
      @(negedge aclk);
      areset = v[i].rst;
      s_mux_valid = v[i].mv;
      s_mux_data = {v[i].pid, v[i].len, v[i].dest};
      s_axis_tvalid = v[i].tv;
      s_axis_tdata = 32'hD000_0000 + i;
      s_axis_tkeep = 4'(i) ^ 4'hA;
      s_axis_tlast = ~v[i].e_tl;
      m_axis_tready = v[i].mr;
      #1;
      chk($sformatf("v%0d s_mux_ready", i), s_mux_ready, v[i].e_mr);
      chk($sformatf("v%0d s_axis_tready", i), s_axis_tready, v[i].e_str);
      chk($sformatf("v%0d m_axis_tvalid", i), m_axis_tvalid, v[i].e_mtv);
      chk($sformatf("v%0d m_axis_tlast", i), m_axis_tlast, v[i].e_tl);
      chk($sformatf("v%0d m_axis_tid", i), m_axis_tid, v[i].e_tid);
      chk($sformatf("v%0d m_axis_tdata", i), m_axis_tdata, 32'hD000_0000 + i);
      chk($sformatf("v%0d m_axis_tkeep", i), m_axis_tkeep, 4'(i) ^ 4'hA);
    end
    // random entries and backpressure against an in-order beat scoreboard
    total = 0;
    for (int e = 0; e < 40; e++) begin
      automatic logic [3:0] p = 4'($urandom);
      automatic logic [2:0] ln = 3'($urandom);
      automatic logic [2:0] ds = 3'($urandom_range(0, 5));
      ents.push_back({p, ln, ds});
      for (int k = 0; k <= int'(ln); k++) begin
        if (ds < 4) exp_q.push_back('{ds, 32'h1000_0000 + total, k == int'(ln), p});
        total++;
      end
    end
    ei = 0; wi = 0; cyc = 0;
    while ((ei < 40 || wi < total) && cyc < 3000) begin
      @(negedge aclk);
      areset = 0;
      s_mux_valid = ei < 40 && $urandom_range(0, 3) != 0;
      if (ei < 40) s_mux_data = ents[ei];
      s_axis_tvalid = wi < total && $urandom_range(0, 3) != 0;
      s_axis_tdata = 32'h1000_0000 + wi;
      s_axis_tkeep = '1;
      s_axis_tlast = 0;
      m_axis_tready = 4'($urandom);
      #1;
      if (|(m_axis_tvalid & m_axis_tready)) begin
        chk("rnd onehot", 64'($countones(m_axis_tvalid)), 1);
        dd = 0;
        for (int d = 0; d < ND; d++) if (m_axis_tvalid[d]) dd = d;
        if (exp_q.size() == 0) chk("rnd extra beat", 1, 0);
        else begin
          b = exp_q.pop_front();
          chk("rnd dest", dd, b.dest);
          chk("rnd tdata", m_axis_tdata, b.d);
          chk("rnd tlast", m_axis_tlast, b.l);
          chk("rnd tid", m_axis_tid, b.pid);
        end
      end
      if (s_mux_valid && s_mux_ready) ei++;
      if (s_axis_tvalid && s_axis_tready) wi++;
      cyc++;
    end
    chk("rnd completed in budget", cyc < 3000, 1);
    chk("rnd beats outstanding", exp_q.size(), 0);
    @(negedge aclk);
    s_mux_valid = 0; s_axis_tvalid = 0;
    #1;
    chk("rnd idle after", {s_mux_ready, s_axis_tready}, 2'b10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
